fe_prefetch_queue: RTL and testbench
====================================

// Module: fe_prefetch_queue
// PURPOSE
//  Instruction byte queue directly upstream of the fetch/length-decode stage.
//  Accepts 16-byte lines from the I-cache/IFU and buffers up to DEPTH lines in a circular store.
//  Presents a byte-aligned 128-bit IR window starting at the current instruction.
//  Retires consume_len bytes per instruction; flush re-seeds the queue on a redirect (branch/exception).
// PARAMETERS
//  LINE_BYTES  16  bytes per fill line (fixed; IR window width / 8)
//  DEPTH       4   lines of storage (power of 2); store = DEPTH*LINE_BYTES = 64 bytes
// PORTS
//  clk            in   1    clock; all state updates on posedge
//  clr            in   1    asynchronous active-low reset
//  fill_valid     in   1    fill_line carries a valid I-cache line
//  fill_ready     out  1    queue can accept a full line this cycle
//  fill_line      in   128  line bytes; byte 0 (lowest address) at [127:120]
//  flush          in   1    redirect: discard all buffered bytes
//  flush_offset   in   4    byte offset of the new EIP within the next filled line
//  consume_valid  in   1    fetch stage retires consume_len bytes
//  consume_len    in   4    instruction length, 1..15
//  ir             out  128  window: byte at rd_ptr on [127:120], rd_ptr+1 on [119:112], ...
//  ir_valid       out  1    at least 16 bytes buffered (the whole window is valid)
//  ir_count       out  7    buffered byte count, 0..64
//  read_ptr       out  6    byte read pointer into the store (debug/visibility)
// BEHAVIOUR
//  Reset (clr=0, async): wr_line=0, read_ptr=0, ir_count=0, skip=0, state=WAIT_FILL.
//  Reset outputs: ir=0, ir_valid=0, fill_ready=1.
//  States:
//   - WAIT_FILL: queue empty after reset or flush; the next accepted fill applies skip.
//     Accepted fill -> RUN.
//   - RUN: normal operation. Count reaching 0 stays in RUN; there is no skip pending.
//  Fill acceptance: fill_ready = (ir_count <= 64-16), from registered count only.
//   - Accepted when fill_valid & fill_ready. The line is written to line slot wr_line.
//   - wr_line increments mod DEPTH.
//   - In RUN: count += 16.
//   - In WAIT_FILL: read_ptr = wr_line*16 + skip; count += 16-skip.
//  Consume acceptance: when consume_valid & ir_valid & consume_len!=0.
//   - read_ptr += consume_len (mod 64); count -= consume_len.
//   - A consume with ir_valid=0 or consume_len=0 is ignored; no state change.
//  Simultaneous fill and consume: both apply.
//   - count_next = count + fill_amt - consume_len.
//   - read_ptr uses the same rule (skip is applied before consume; consume cannot occur in WAIT_FILL since count=0).
//  Flush has priority over fill and consume in the same cycle; both are dropped.
//   - wr_line=0, read_ptr=0, count=0, skip=flush_offset, state=WAIT_FILL.
//   - fill_ready is 1 the next cycle.
//  ir is combinational from store and read_ptr. It reflects a fill or consume the cycle after acceptance (1-cycle latency).
//  ir byte i = store[(read_ptr+i) mod 64] for i < ir_count, else 8'h00 (zero-masked).
//  Wrap-around: the window may straddle slot DEPTH-1 -> slot 0; must be seamless.
//  ir_valid = (ir_count >= 16), registered-derived, no combinational path from inputs.
//  Invariants:
//   - ir_count never exceeds 64; underflow is impossible by the acceptance rules.
//   - All pointer arithmetic is modulo 64 bytes / DEPTH lines.
//  Reset mid-operation: asynchronous return to reset values; in-flight fill/consume lost.
// TESTING
//  1. Reset, then 1 fill of bytes 00..0F -> ir_count=16, ir_valid=1, ir[127:120]=00, ir[7:0]=0F.
//  2. Fill 4 lines (bytes 00..3F) -> fill_ready=0 at count=64.
//     Consume 5 -> fill_ready stays 0 (59>48).
//     Consume 11 -> fill_ready=1 (48).
//  3. Wrap: 4 lines, consume 15+15+15+10 (count 9), fill 40..4F.
//     -> ir starts at byte 37, crosses the slot3->slot0 boundary, ir_count=25.
//  4. Flush with flush_offset=5, then fill 80..8F -> read_ptr=5, ir_count=11, ir_valid=0.
//     ir[127:120]=85, low 5 bytes zero.
//  5. Same-cycle fill + consume 7 at count 16 -> count 25.
//     Same-cycle flush + fill + consume -> count 0, WAIT_FILL.
//  6. Assert clr mid-stream with count=40 -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/fe_prefetch_queue.sv
// Prefetch byte queue ahead of length decode.
// Buffers fill lines and presents a byte-aligned IR window.
module fe_prefetch_queue #(
    parameter int LINE_BYTES = 16,
    parameter int DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  clr,
    input  logic                                  fill_valid,
    output logic                                  fill_ready,
    input  logic [8*LINE_BYTES-1:0]               fill_line,
    input  logic                                  flush,
    input  logic [$clog2(LINE_BYTES)-1:0]         flush_offset,
    input  logic                                  consume_valid,
    input  logic [$clog2(LINE_BYTES)-1:0]         consume_len,
    output logic [8*LINE_BYTES-1:0]               ir,
    output logic                                  ir_valid,
    output logic [$clog2(DEPTH*LINE_BYTES):0]     ir_count,
    output logic [$clog2(DEPTH*LINE_BYTES)-1:0]   read_ptr
);

    localparam int STORE = DEPTH * LINE_BYTES;
    localparam int PW    = $clog2(STORE);
    localparam int CW    = PW + 1;
    localparam int BW    = $clog2(LINE_BYTES);
    localparam int LW    = $clog2(DEPTH);

    typedef enum logic {
        WAIT_FILL,
        RUN
    } state_t;

    state_t          state;
    logic [LW-1:0]   wr_line;
    logic [BW-1:0]   skip;
    logic [7:0]      mem [STORE];

    logic            fill_acc;
    logic            cons_acc;
    logic [CW-1:0]   fill_amt;
    logic [CW-1:0]   cons_amt;
    logic [PW-1:0]   rp_base;
    logic [PW-1:0]   rp_next;
    logic [CW-1:0]   cnt_next;

    assign fill_ready = (ir_count <= CW'(STORE - LINE_BYTES));
    assign ir_valid   = (ir_count >= CW'(LINE_BYTES));

    assign fill_acc = fill_valid & fill_ready;
    assign cons_acc = consume_valid & ir_valid & (consume_len != '0);

    // First fill after reset/flush re-seeds the pointer past the skipped bytes.
    always_comb begin
        fill_amt = '0;
        rp_base  = read_ptr;
        if (fill_acc) begin
            if (state == WAIT_FILL) begin
                fill_amt = CW'(LINE_BYTES) - CW'(skip);
                rp_base  = {wr_line, skip};
            end else begin
                fill_amt = CW'(LINE_BYTES);
            end
        end
    end

    always_comb begin
        cons_amt = '0;
        if (cons_acc) begin
            cons_amt = CW'(consume_len);
        end
    end

    assign rp_next  = rp_base + PW'(cons_amt);
    assign cnt_next = ir_count + fill_amt - cons_amt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= WAIT_FILL;
            wr_line  <= '0;
            read_ptr <= '0;
            ir_count <= '0;
            skip     <= '0;
        end else if (flush) begin
            state    <= WAIT_FILL;
            wr_line  <= '0;
            read_ptr <= '0;
            ir_count <= '0;
            skip     <= flush_offset;
        end else begin
            if (fill_acc) begin
                wr_line <= wr_line + 1'b1;
                state   <= RUN;
            end
            read_ptr <= rp_next;
            ir_count <= cnt_next;
        end
    end

    // Byte storage is data only; stale bytes are masked by ir_count.
    always_ff @(posedge clk) begin
        if (fill_acc && !flush) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
                mem[{wr_line, BW'(k)}] <= fill_line[8*(LINE_BYTES-1-k) +: 8];
            end
        end
    end

    always_comb begin
        ir = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (ir_count > CW'(i)) begin
                ir[8*(LINE_BYTES-1-i) +: 8] = mem[read_ptr + PW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_fe_prefetch_queue.sv
// Bench for fe_prefetch_queue: directed scenarios
// plus randomized traffic against a byte-queue model.
module tb_fe_prefetch_queue;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         fill_valid = 1'b0;
    logic         fill_ready;
    logic [127:0] fill_line = '0;
    logic         flush = 1'b0;
    logic [3:0]   flush_offset = '0;
    logic         consume_valid = 1'b0;
    logic [3:0]   consume_len = '0;
    logic [127:0] ir;
    logic         ir_valid;
    logic [6:0]   ir_count;
    logic [5:0]   read_ptr;

    int checks = 0;
    int errors = 0;

    fe_prefetch_queue #(.LINE_BYTES(16), .DEPTH(4)) dut (
        .clk           (clk),
        .clr           (clr),
        .fill_valid    (fill_valid),
        .fill_ready    (fill_ready),
        .fill_line     (fill_line),
        .flush         (flush),
        .flush_offset  (flush_offset),
        .consume_valid (consume_valid),
        .consume_len   (consume_len),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .ir_count      (ir_count),
        .read_ptr      (read_ptr)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mkline(input logic [7:0] base);
        logic [127:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[127-8*k -: 8] = base + 8'(k);
        return l;
    endfunction

    task automatic step(input logic fv, input logic [127:0] line,
                        input logic fl, input logic [3:0] fo,
                        input logic cv, input logic [3:0] cl);
        fill_valid    = fv;
        fill_line     = line;
        flush         = fl;
        flush_offset  = fo;
        consume_valid = cv;
        consume_len   = cl;
        @(posedge clk);
        #1;
        fill_valid    = 1'b0;
        flush         = 1'b0;
        consume_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic fill(input logic [7:0] base);
        step(1'b1, mkline(base), 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic consume(input logic [3:0] n);
        step(1'b0, '0, 1'b0, 4'd0, 1'b1, n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++; if (ir !== '0) begin errors++; $display("FAIL reset_ir got %h exp 0", ir); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b exp 0", ir_valid); end
        checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL reset_fill_ready got %b exp 1", fill_ready); end
        checks++; if (ir_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ir_count); end
        checks++; if (read_ptr !== 6'd0) begin errors++; $display("FAIL reset_read_ptr got %0d exp 0", read_ptr); end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_single_fill();
        fill(8'h00);
        checks++; if (ir_count !== 7'd16) begin errors++; $display("FAIL single_count got %0d exp 16", ir_count); end
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ir_valid); end
        checks++; if (ir[127:120] !== 8'h00) begin errors++; $display("FAIL single_b0 got %h exp 00", ir[127:120]); end
        checks++; if (ir[7:0] !== 8'h0F) begin errors++; $display("FAIL single_b15 got %h exp 0f", ir[7:0]); end
        checks++; if (ir !== mkline(8'h00)) begin errors++; $display("FAIL single_ir got %h", ir); end
    endtask

    task automatic test_fill_ready();
        do_reset();
        for (int l = 0; l < 4; l++) fill(8'(16 * l));
        checks++; if (ir_count !== 7'd64) begin errors++; $display("FAIL full_count got %0d exp 64", ir_count); end
        checks++; if (fill_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", fill_ready); end
        fill(8'hEE);
        checks++; if (ir_count !== 7'd64) begin errors++; $display("FAIL full_drop got %0d exp 64", ir_count); end
        consume(4'd5);
        checks++; if (ir_count !== 7'd59) begin errors++; $display("FAIL c5_count got %0d exp 59", ir_count); end
        checks++; if (fill_ready !== 1'b0) begin errors++; $display("FAIL c5_ready got %b exp 0", fill_ready); end
        checks++; if (ir[127:120] !== 8'h05) begin errors++; $display("FAIL c5_b0 got %h exp 05", ir[127:120]); end
        consume(4'd11);
        checks++; if (ir_count !== 7'd48) begin errors++; $display("FAIL c11_count got %0d exp 48", ir_count); end
        checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL c11_ready got %b exp 1", fill_ready); end
        checks++; if (read_ptr !== 6'd16) begin errors++; $display("FAIL c11_ptr got %0d exp 16", read_ptr); end
        consume(4'd0);
        checks++; if (ir_count !== 7'd48) begin errors++; $display("FAIL c0_count got %0d exp 48", ir_count); end
    endtask

    task automatic test_wrap();
        logic [127:0] exp;
        do_reset();
        for (int l = 0; l < 4; l++) fill(8'(16 * l));
        consume(4'd15);
        consume(4'd15);
        consume(4'd15);
        consume(4'd10);
        checks++; if (ir_count !== 7'd9) begin errors++; $display("FAIL wrap_pre_count got %0d exp 9", ir_count); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL wrap_pre_valid got %b exp 0", ir_valid); end
        consume(4'd3);
        checks++; if (ir_count !== 7'd9) begin errors++; $display("FAIL wrap_ign_count got %0d exp 9", ir_count); end
        fill(8'h40);
        for (int k = 0; k < 16; k++) exp[127-8*k -: 8] = 8'h37 + 8'(k);
        checks++; if (ir_count !== 7'd25) begin errors++; $display("FAIL wrap_count got %0d exp 25", ir_count); end
        checks++; if (read_ptr !== 6'd55) begin errors++; $display("FAIL wrap_ptr got %0d exp 55", read_ptr); end
        checks++; if (ir !== exp) begin errors++; $display("FAIL wrap_ir got %h exp %h", ir, exp); end
    endtask

    task automatic test_flush_offset();
        step(1'b0, '0, 1'b1, 4'd5, 1'b0, 4'd0);
        checks++; if (ir_count !== 7'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", ir_count); end
        checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", fill_ready); end
        fill(8'h80);
        checks++; if (read_ptr !== 6'd5) begin errors++; $display("FAIL skip_ptr got %0d exp 5", read_ptr); end
        checks++; if (ir_count !== 7'd11) begin errors++; $display("FAIL skip_count got %0d exp 11", ir_count); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL skip_valid got %b exp 0", ir_valid); end
        checks++; if (ir[127:120] !== 8'h85) begin errors++; $display("FAIL skip_b0 got %h exp 85", ir[127:120]); end
        checks++; if (ir[47:40] !== 8'h8F) begin errors++; $display("FAIL skip_b10 got %h exp 8f", ir[47:40]); end
        checks++; if (ir[39:0] !== 40'h0) begin errors++; $display("FAIL skip_mask got %h exp 0", ir[39:0]); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        fill(8'h00);
        step(1'b1, mkline(8'h10), 1'b0, 4'd0, 1'b1, 4'd7);
        checks++; if (ir_count !== 7'd25) begin errors++; $display("FAIL sim_count got %0d exp 25", ir_count); end
        checks++; if (read_ptr !== 6'd7) begin errors++; $display("FAIL sim_ptr got %0d exp 7", read_ptr); end
        checks++; if (ir[127:120] !== 8'h07) begin errors++; $display("FAIL sim_b0 got %h exp 07", ir[127:120]); end
        step(1'b1, mkline(8'h20), 1'b1, 4'd3, 1'b1, 4'd4);
        checks++; if (ir_count !== 7'd0) begin errors++; $display("FAIL sflush_count got %0d exp 0", ir_count); end
        checks++; if (read_ptr !== 6'd0) begin errors++; $display("FAIL sflush_ptr got %0d exp 0", read_ptr); end
        fill(8'h50);
        checks++; if (read_ptr !== 6'd3) begin errors++; $display("FAIL sflush_skip_ptr got %0d exp 3", read_ptr); end
        checks++; if (ir_count !== 7'd13) begin errors++; $display("FAIL sflush_skip_count got %0d exp 13", ir_count); end
        checks++; if (ir[127:120] !== 8'h53) begin errors++; $display("FAIL sflush_b0 got %h exp 53", ir[127:120]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int l = 0; l < 3; l++) fill(8'(16 * l));
        consume(4'd8);
        checks++; if (ir_count !== 7'd40) begin errors++; $display("FAIL ar_pre_count got %0d exp 40", ir_count); end
        #2;
        clr = 1'b0;
        #1;
        checks++; if (ir !== '0) begin errors++; $display("FAIL ar_ir got %h exp 0", ir); end
        checks++; if (ir_count !== 7'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", ir_count); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", ir_valid); end
        checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %b exp 1", fill_ready); end
        checks++; if (read_ptr !== 6'd0) begin errors++; $display("FAIL ar_ptr got %0d exp 0", read_ptr); end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0]   q[$];
        int           rp;
        int           wr;
        int           skip;
        bit           waiting;
        logic [127:0] line;
        logic [127:0] exp;
        bit           fv, fl, cv;
        logic [3:0]   fo, cl;
        do_reset();
        q.delete();
        rp = 0; wr = 0; skip = 0; waiting = 1;
        for (int n = 0; n < 3000; n++) begin
            fv   = ($urandom_range(0, 9) < 7);
            cv   = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 99) < 3);
            fo   = 4'($urandom_range(0, 15));
            cl   = 4'($urandom_range(0, 15));
            line = {$urandom, $urandom, $urandom, $urandom};
            if (fl) begin
                q.delete();
                rp = 0; wr = 0; skip = int'(fo); waiting = 1;
            end else begin
                bit fa, ca;
                fa = fv && (q.size() <= 48);
                ca = cv && (q.size() >= 16) && (cl != 0);
                if (ca) begin
                    for (int k = 0; k < int'(cl); k++) void'(q.pop_front());
                end
                if (fa) begin
                    if (waiting) begin
                        rp = wr * 16 + skip;
                        for (int k = skip; k < 16; k++) q.push_back(line[127-8*k -: 8]);
                        waiting = 0;
                    end else begin
                        for (int k = 0; k < 16; k++) q.push_back(line[127-8*k -: 8]);
                    end
                    wr = (wr + 1) % 4;
                end
                if (ca) rp = (rp + int'(cl)) % 64;
            end
            step(fv, line, fl, fo, cv, cl);
            exp = '0;
            for (int k = 0; k < 16; k++) if (k < q.size()) exp[127-8*k -: 8] = q[k];
            checks++; if (ir_count !== 7'(q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, ir_count, q.size()); end
            checks++; if (read_ptr !== 6'(rp)) begin errors++; $display("FAIL rnd_ptr cyc %0d got %0d exp %0d", n, read_ptr, rp); end
            checks++; if (ir !== exp) begin errors++; $display("FAIL rnd_ir cyc %0d got %h exp %h", n, ir, exp); end
            checks++; if (ir_valid !== (q.size() >= 16)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b", n, ir_valid); end
            checks++; if (fill_ready !== (q.size() <= 48)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b", n, fill_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_fill_ready();
        test_wrap();
        test_flush_offset();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
